// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, 2N-bit dividend by N-bit divisor.
// Ports: clk, rst_n (async, active-low), start, dividend[2N-1:0], divisor[N-1:0]
//        -> busy, done (1-cycle pulse), quotient, remainder, div_by_zero, overflow.
module seq_divider #(
    parameter int N = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  dvs_q;
    logic [N-1:0]  rem_q;
    // Low dividend bits shift out of the top while quotient bits
    // shift in at the bottom.
    logic [N-1:0]  quo_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    trial;
    logic [N-1:0]  diff;
    logic          ge;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;
    logic [N-1:0]  hi;
    logic          last;

    assign hi = dividend[2*N-1:N];

    // The partial remainder is always < divisor, so the shifted value
    // needs N+1 bits; when it is >= divisor the difference fits in N.
    assign trial    = {rem_q, quo_q[N-1]};
    assign ge       = (trial >= {1'b0, dvs_q});
    assign diff     = trial[N-1:0] - dvs_q;
    assign rem_next = ge ? diff : trial[N-1:0];
    assign quo_next = {quo_q[N-2:0], ge};
    assign last     = (cnt_q == CW'(N - 1));

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvs_q <= divisor;
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (hi >= divisor) begin
                            // Quotient would need more than N bits.
                            state       <= S_DONE;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            rem_q <= hi;
                            quo_q <= dividend[N-1:0];
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state       <= S_DONE;
                        quotient    <= quo_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (N=10).
// Stimulus pushes expected results; a monitor pops them on each done pulse.
module tb_seq_divider;

    localparam int N = 10;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2*N-1:0]  dividend;
    logic [N-1:0]    divisor;
    logic            busy;
    logic            done;
    logic [N-1:0]    quotient;
    logic [N-1:0]    remainder;
    logic            div_by_zero;
    logic            overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    typedef struct {
        logic [2*N-1:0] dvd;
        logic [N-1:0]   dvs;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           dz;
        logic           ov;
        int             due;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        edges++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, req, edges);
        end
    endtask

    function automatic exp_t mk(input logic [2*N-1:0] a,
                                input logic [N-1:0] b,
                                input logic [N-1:0] q,
                                input logic [N-1:0] r,
                                input logic dz, input logic ov,
                                input int due);
        exp_t e;
        e.dvd = a; e.dvs = b; e.q = q; e.r = r;
        e.dz = dz; e.ov = ov; e.due = due;
        return e;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_one_cycle", prev_done, 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_edge", edges, e.due);
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", div_by_zero, e.dz);
                    check("overflow", overflow, e.ov);
                    check("busy_in_done", busy, 1);
                    if (!e.dz && !e.ov) begin
                        check("invariant",
                              int'(quotient) * int'(e.dvs) + int'(remainder),
                              int'(e.dvd));
                        check("rem_lt_div", remainder < e.dvs, 1);
                    end
                end
            end else if (sb.size() > 0 && edges > sb[0].due) begin
                check("missed_done", done, 1);
                void'(sb.pop_front());
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic dz, input logic ov);
        int lat;
        lat = (dz || ov) ? 0 : N;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(mk(a, b, q, r, dz, ov, edges + 1 + lat));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        dividend = ~a;
        divisor  = ~b;
        repeat (lat + 1) @(negedge clk);
    endtask

    initial begin
        int e0;
        logic [N-1:0]   rb;
        logic [2*N-1:0] ra;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(20'd100, 10'd7, 10'd14, 10'd2, 1'b0, 1'b0);
        issue(20'd1046529, 10'd1023, 10'd1023, 10'd0, 1'b0, 1'b0);
        issue(20'd0, 10'd1, 10'd0, 10'd0, 1'b0, 1'b0);
        issue(20'd5000, 10'd0, 10'h3FF, 10'd904, 1'b1, 1'b0);
        issue(20'd5120, 10'd5, 10'h3FF, 10'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 10'h3FF);
        check("hold_ovf", overflow, 1);

        // Abort mid-CALC with an asynchronous reset pulse.
        @(negedge clk);
        dividend = 20'd100;
        divisor  = 10'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_ovf", overflow, 0);
        #1;
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("idle_after_abort", busy, 0);
        issue(20'd100, 10'd7, 10'd14, 10'd2, 1'b0, 1'b0);

        // Back-to-back with start held; operands change mid-CALC.
        @(negedge clk);
        e0       = edges + 1;
        dividend = 20'd1000;
        divisor  = 10'd3;
        start    = 1'b1;
        sb.push_back(mk(20'd1000, 10'd3, 10'd333, 10'd1, 1'b0, 1'b0,
                        e0 + N));
        sb.push_back(mk(20'd50000, 10'd77, 10'd649, 10'd27, 1'b0, 1'b0,
                        e0 + (N + 2) + N));
        sb.push_back(mk(20'd12345, 10'd99, 10'd124, 10'd69, 1'b0, 1'b0,
                        e0 + 2 * (N + 2) + N));
        while (edges < e0 + 3) @(negedge clk);
        dividend = 20'd50000;
        divisor  = 10'd77;
        while (edges < e0 + 15) @(negedge clk);
        dividend = 20'd12345;
        divisor  = 10'd99;
        while (edges < e0 + 27) @(negedge clk);
        dividend = 20'hFFFFF;
        divisor  = 10'd0;
        while (edges < e0 + 30) @(negedge clk);
        start = 1'b0;
        while (edges < e0 + 37) @(negedge clk);
        check("idle_after_b2b", busy, 0);

        for (int i = 0; i < 1000; i++) begin
            rb = 10'($urandom_range(1, 1023));
            ra = 20'($urandom % (int'(rb) * 1024));
            issue(ra, rb, 10'(ra / 20'(rb)), 10'(ra % 20'(rb)),
                  1'b0, 1'b0);
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check("pending_results", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
